// File: rtl/clint_mh.sv
// Multi-hart CLINT: prescaled 64-bit mtime, per-hart mtimecmp and msip,
// registered single-entry response channel with SLVERR on unmapped words.
module clint_mh #(
   parameter int NHART    = 2,
   parameter int TICK_DIV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic             req_i,
   input  logic [63:0]      addr_i,
   input  logic [63:0]      data_write_i,
   input  logic [7:0]       wstrb_i,
   output logic             ready_o,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [63:0]      data_read_o,
   output logic [1:0]       resp_o,
   output logic [NHART-1:0] time_irq_o,
   output logic [NHART-1:0] sip_o
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   logic [63:0]      mtime;
   logic [63:0]      mtimecmp [NHART];
   logic [NHART-1:0] msip;
   logic [NHART-1:0] tirq;
   logic [PW-1:0]    pcnt;
   logic             resp_valid;
   logic [63:0]      rdata;
   logic [1:0]       resp;

   logic [63:0] bmask;
   logic [63:0] rd;
   logic [2:0]  sip_w;
   logic [3:0]  cmp_h;
   logic        sel_sip, sel_cmp, sel_time, mapped;
   logic        accept, wr, tick;
   logic        unused_addr;

   assign unused_addr = ^{addr_i[63:16], addr_i[2:0]};

   assign sip_w = addr_i[5:3];
   assign cmp_h = addr_i[6:3];

   // A msip word holds two harts; it is mapped if its lower lane exists.
   assign sel_sip  = (addr_i[15:6] == '0) && (int'(sip_w) * 2 < NHART);
   assign sel_cmp  = (addr_i[15:7] == 9'h080) && (int'(cmp_h) < NHART);
   assign sel_time = (addr_i[15:3] == 13'h17FF);
   assign mapped   = sel_sip || sel_cmp || sel_time;

   assign ready_o = !resp_valid || resp_ready_i;
   assign accept  = valid_i && ready_o;
   assign wr      = accept && req_i && mapped;
   assign tick    = (pcnt == PMAX);

   always_comb begin
      bmask = '0;
      for (int i = 0; i < 8; i++)
         bmask[i*8 +: 8] = {8{wstrb_i[i]}};
   end

   always_comb begin
      rd = '0;
      for (int h = 0; h < NHART; h++) begin
         if (sel_sip && int'(sip_w) == h / 2) begin
            if (h % 2 == 0) rd[0] = msip[h];
            else            rd[32] = msip[h];
         end
         if (sel_cmp && int'(cmp_h) == h)
            rd = mtimecmp[h];
      end
      if (sel_time)
         rd = mtime;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtime      <= '0;
         pcnt       <= '0;
         msip       <= '0;
         tirq       <= '0;
         resp_valid <= 1'b0;
         rdata      <= '0;
         resp       <= 2'b00;
         for (int h = 0; h < NHART; h++)
            mtimecmp[h] <= '1;
      end else begin
         // An mtime write replaces the tick and restarts the prescaler.
         if (wr && sel_time) begin
            mtime <= (mtime & ~bmask) | (data_write_i & bmask);
            pcnt  <= '0;
         end else if (tick) begin
            mtime <= mtime + 64'd1;
            pcnt  <= '0;
         end else begin
            pcnt <= pcnt + PW'(1);
         end
         for (int h = 0; h < NHART; h++) begin
            tirq[h] <= (mtime >= mtimecmp[h]);
            if (wr && sel_cmp && int'(cmp_h) == h)
               mtimecmp[h] <= (mtimecmp[h] & ~bmask)
                            | (data_write_i & bmask);
            if (wr && sel_sip && int'(sip_w) == h / 2) begin
               if (h % 2 == 0) begin
                  if (wstrb_i[0]) msip[h] <= data_write_i[0];
               end else begin
                  if (wstrb_i[4]) msip[h] <= data_write_i[32];
               end
            end
         end
         if (accept) begin
            resp_valid <= 1'b1;
            rdata      <= (req_i || !mapped) ? 64'd0 : rd;
            resp       <= mapped ? 2'b00 : 2'b10;
         end else if (resp_ready_i) begin
            resp_valid <= 1'b0;
         end
      end
   end

   assign resp_valid_o = resp_valid;
   assign data_read_o  = rdata;
   assign resp_o       = resp;
   assign time_irq_o   = tirq;
   assign sip_o        = msip;

endmodule

// File: tb/tb_clint_mh.sv
// Directed bench for clint_mh: a TICK_DIV=1 and a TICK_DIV=4 instance
// share one request bus, steered by sel.
module tb_clint_mh;
   logic        clk = 1'b0;
   logic        rst;
   logic        sel, valid, req, resp_ready;
   logic [63:0] addr, wdata;
   logic [7:0]  wstrb;

   logic        ready_a, ready_b, rv_a, rv_b;
   logic [63:0] rd_a, rd_b;
   logic [1:0]  rs_a, rs_b, tirq_a, tirq_b, sip_a, sip_b;

   logic        ready, rv;
   logic [63:0] rd;
   logic [1:0]  rs;

   int n;
   int vecs;
   int errs;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   always #5 clk = ~clk;

   always @(posedge clk)
      if (rst) n <= 0;
      else     n <= n + 1;

   assign ready = sel ? ready_b : ready_a;
   assign rv    = sel ? rv_b    : rv_a;
   assign rd    = sel ? rd_b    : rd_a;
   assign rs    = sel ? rs_b    : rs_a;

   clint_mh #(.NHART(2), .TICK_DIV(1)) u_a (
      .clk(clk), .rst(rst),
      .valid_i(valid & ~sel), .req_i(req), .addr_i(addr),
      .data_write_i(wdata), .wstrb_i(wstrb), .ready_o(ready_a),
      .resp_valid_o(rv_a), .resp_ready_i(resp_ready),
      .data_read_o(rd_a), .resp_o(rs_a),
      .time_irq_o(tirq_a), .sip_o(sip_a)
   );

   clint_mh #(.NHART(2), .TICK_DIV(4)) u_b (
      .clk(clk), .rst(rst),
      .valid_i(valid & sel), .req_i(req), .addr_i(addr),
      .data_write_i(wdata), .wstrb_i(wstrb), .ready_o(ready_b),
      .resp_valid_o(rv_b), .resp_ready_i(resp_ready),
      .data_read_o(rd_b), .resp_o(rs_b),
      .time_irq_o(tirq_b), .sip_o(sip_b)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   // Issue one request; returns after the accept edge with the response.
   task automatic xact(input logic s, input logic w,
                       input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] st, input logic [1:0] er,
                       output logic [63:0] r);
      int k;
      sel = s; valid = 1'b1; req = w;
      addr = a; wdata = d; wstrb = st;
      #1;
      k = 0;
      while (!ready && k < 8) begin
         @(posedge clk); #1;
         k++;
      end
      chk("accept", 64'(ready), 64'd1);
      @(posedge clk); #1;
      valid = 1'b0;
      chk("rvalid", 64'(rv), 64'd1);
      chk("resp", 64'(rs), 64'(er));
      r = rd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] r;
      int k0;
      rst = 1'b1; sel = 1'b0; valid = 1'b0; req = 1'b0;
      addr = '0; wdata = '0; wstrb = '0; resp_ready = 1'b1;
      vecs = 0; errs = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rv",    64'(rv_a),    64'd0);
      chk("rst_rd",    rd_a,         64'd0);
      chk("rst_rs",    64'(rs_a),    64'd0);
      chk("rst_irq",   64'(tirq_a),  64'd0);
      chk("rst_sip",   64'(sip_a),   64'd0);
      chk("rst_ready", 64'(ready_a), 64'd1);
      rst = 1'b0;

      while (n < 10) begin
         @(posedge clk); #1;
         chk("irq_idle", 64'(tirq_a), 64'd0);
      end
      xact(1'b0, 1'b0, 64'hBFF8, 64'd0, 8'h00, 2'b00, r);
      chk("mtime10", r, 64'd10);

      xact(1'b0, 1'b1, 64'h4008, 64'd20, 8'hFF, 2'b00, r);
      chk("wr_data0", r, 64'd0);
      while (n < 24) begin
         @(posedge clk); #1;
         chk("irq_cmp", 64'(tirq_a), (n >= 21) ? 64'd2 : 64'd0);
      end

      xact(1'b0, 1'b1, 64'h0000, 64'h1_0000_0000, 8'hF0, 2'b00, r);
      chk("sip_hi", 64'(sip_a), 64'd2);
      xact(1'b0, 1'b0, 64'h0000, 64'd0, 8'h00, 2'b00, r);
      chk("sip_rd", r, 64'h1_0000_0000);
      xact(1'b0, 1'b1, 64'h0004, 64'd0, 8'hEE, 2'b00, r);
      chk("sip_nostrb", 64'(sip_a), 64'd2);
      xact(1'b0, 1'b1, 64'h0004, ONES, 8'h01, 2'b00, r);
      chk("sip_lo", 64'(sip_a), 64'd3);
      xact(1'b0, 1'b0, 64'h0000, 64'd0, 8'h00, 2'b00, r);
      chk("sip_rd2", r, 64'h1_0000_0001);

      xact(1'b0, 1'b0, 64'h8000, 64'd0, 8'h00, 2'b10, r);
      chk("err_8000", r, 64'd0);
      xact(1'b0, 1'b0, 64'h4010, 64'd0, 8'h00, 2'b10, r);
      chk("err_4010", r, 64'd0);
      xact(1'b0, 1'b1, 64'h4010, 64'd0, 8'hFF, 2'b10, r);
      xact(1'b0, 1'b1, 64'h0008, ONES, 8'hFF, 2'b10, r);
      chk("err_sip", 64'(sip_a), 64'd3);
      xact(1'b0, 1'b0, 64'h4008, 64'd0, 8'h00, 2'b00, r);
      chk("cmp1_kept", r, 64'd20);
      xact(1'b0, 1'b0, 64'h4000, 64'd0, 8'h00, 2'b00, r);
      chk("cmp0_rst", r, ONES);
      xact(1'b0, 1'b0, 64'hBFFC, 64'd0, 8'h00, 2'b00, r);
      chk("mtime_lsb", r, 64'(n - 1));
      chk("irq_kept", 64'(tirq_a), 64'd2);

      @(posedge clk); #1;
      resp_ready = 1'b0;
      sel = 1'b0; valid = 1'b1; req = 1'b0; addr = 64'h4008;
      @(posedge clk); #1;
      chk("bp_rv", 64'(rv), 64'd1);
      chk("bp_rd", rd, 64'd20);
      addr = 64'h0000;
      repeat (3) begin
         @(posedge clk); #1;
         chk("bp_ready", 64'(ready), 64'd0);
         chk("bp_hold_rv", 64'(rv), 64'd1);
         chk("bp_hold_rd", rd, 64'd20);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("b2b_rv1", 64'(rv), 64'd1);
      chk("b2b_rd1", rd, 64'h1_0000_0001);
      addr = 64'h4000;
      @(posedge clk); #1;
      chk("b2b_rv2", 64'(rv), 64'd1);
      chk("b2b_rd2", rd, ONES);
      valid = 1'b0;
      @(posedge clk); #1;
      chk("b2b_idle", 64'(rv), 64'd0);

      repeat (6) begin
         xact(1'b1, 1'b0, 64'hBFF8, 64'd0, 8'h00, 2'b00, r);
         chk("div4", r, 64'((n - 1) / 4));
      end
      while (n % 4 != 3) begin
         @(posedge clk); #1;
      end
      xact(1'b1, 1'b1, 64'hBFF8, ONES, 8'hFF, 2'b00, r);
      k0 = n;
      repeat (6) begin
         xact(1'b1, 1'b0, 64'hBFF8, 64'd0, 8'h00, 2'b00, r);
         chk("wrap", r, (n - k0 >= 5) ? 64'd0 : ONES);
      end

      sel = 1'b0;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      valid = 1'b1; req = 1'b0; addr = 64'h4008;
      @(posedge clk); #1;
      valid = 1'b0;
      chk("mid_rv", 64'(rv_a), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      resp_ready = 1'b1;
      chk("mid_rst_rv",  64'(rv_a),    64'd0);
      chk("mid_rst_rd",  rd_a,         64'd0);
      chk("mid_rst_sip", 64'(sip_a),   64'd0);
      chk("mid_rst_irq", 64'(tirq_a),  64'd0);
      chk("mid_rst_rdy", 64'(ready_a), 64'd1);
      xact(1'b0, 1'b0, 64'hBFF8, 64'd0, 8'h00, 2'b00, r);
      chk("mid_mtime", r, 64'd0);
      xact(1'b0, 1'b0, 64'h4008, 64'd0, 8'h00, 2'b00, r);
      chk("mid_cmp1", r, ONES);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
